// File: rtl/uart_transmitter.sv
// UART serialiser with a small byte FIFO; one bit per external baud_tick,
// frames go out start / LSB-first data / optional parity / stop(s), back-to-back when queued.
module uart_transmitter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                        clock,
  input  logic                        rst_n,
  input  logic                        baud_tick,
  input  logic [DATA_WIDTH-1:0]       tx_DATA,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic                        txd,
  output logic                        tx_busy,
  output logic                        tx_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);
  localparam logic ODD_BIT = (PARITY_ODD != 0);
  localparam logic PAR_ON  = (PARITY_EN != 0);
  localparam logic ONE_STOP = (STOP_BITS < 2);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e                  r_state, w_state_next;
  logic [DATA_WIDTH-1:0]   r_shift, w_shift_next;
  logic [BIT_W-1:0]        r_bit_cnt, w_bit_cnt_next;
  logic                    r_stop_cnt, w_stop_cnt_next;
  logic                    r_parity, w_parity_next;
  logic                    r_txd, w_txd_next;
  logic                    r_tx_done, w_done_next;

  logic [DATA_WIDTH-1:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]        r_count;

  logic                    w_push, w_pop, w_nonempty, w_last_stop;
  logic [DATA_WIDTH-1:0]   w_head;

  assign tx_ready   = (r_count < CNT_W'(FIFO_DEPTH));
  assign w_push     = tx_valid & tx_ready;
  assign w_nonempty = (r_count != '0);
  assign w_head     = r_mem[r_rd_ptr];
  assign w_last_stop = ONE_STOP | r_stop_cnt;

  assign txd        = r_txd;
  assign tx_busy    = (r_state != StIdle);
  assign tx_done    = r_tx_done;
  assign fifo_count = r_count;

  // Byte FIFO; a push into an empty FIFO only becomes visible to the FSM next cycle.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= tx_DATA;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_parity   <= 1'b0;
      r_txd      <= 1'b1;
      r_tx_done  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_shift    <= w_shift_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_stop_cnt <= w_stop_cnt_next;
      r_parity   <= w_parity_next;
      r_txd      <= w_txd_next;
      r_tx_done  <= w_done_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_shift_next    = r_shift;
    w_bit_cnt_next  = r_bit_cnt;
    w_stop_cnt_next = r_stop_cnt;
    w_parity_next   = r_parity;
    w_txd_next      = r_txd;
    w_done_next     = 1'b0;
    w_pop           = 1'b0;

    if (baud_tick) begin
      unique case (r_state)
        StIdle: begin
          if (w_nonempty) begin
            w_pop         = 1'b1;
            w_shift_next  = w_head;
            w_parity_next = (^w_head) ^ ODD_BIT;
            w_txd_next    = 1'b0;
            w_state_next  = StStart;
          end
        end
        StStart: begin
          w_txd_next     = r_shift[0];
          w_bit_cnt_next = '0;
          w_state_next   = StData;
        end
        StData: begin
          if (r_bit_cnt == LAST_BIT) begin
            if (PAR_ON) begin
              w_txd_next   = r_parity;
              w_state_next = StParity;
            end else begin
              w_txd_next      = 1'b1;
              w_stop_cnt_next = 1'b0;
              w_state_next    = StStop;
            end
          end else begin
            w_shift_next   = r_shift >> 1;
            w_txd_next     = r_shift[1];
            w_bit_cnt_next = r_bit_cnt + BIT_W'(1);
          end
        end
        StParity: begin
          w_txd_next      = 1'b1;
          w_stop_cnt_next = 1'b0;
          w_state_next    = StStop;
        end
        StStop: begin
          if (w_last_stop) begin
            w_done_next = 1'b1;
            // Chain straight into the next start bit so queued frames leave no idle gap.
            if (w_nonempty) begin
              w_pop         = 1'b1;
              w_shift_next  = w_head;
              w_parity_next = (^w_head) ^ ODD_BIT;
              w_txd_next    = 1'b0;
              w_state_next  = StStart;
            end else begin
              w_txd_next   = 1'b1;
              w_state_next = StIdle;
            end
          end else begin
            w_stop_cnt_next = 1'b1;
          end
        end
        default: begin
          w_txd_next   = 1'b1;
          w_state_next = StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: default, even/odd parity and two-stop-bit instances
// share clock, reset, baud_tick and data; each has its own valid and outputs.
module tb_uart_transmitter;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic       baud_tick = 1'b0;
  logic [7:0] tx_DATA = 8'h00;
  logic [3:0] vld = 4'b0000;
  logic [3:0] ready_a, txd_a, busy_a, done_a;
  logic [2:0] cnt_a [4];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  uart_transmitter u_dut0 (
    .clock(clock), .rst_n(rst_n), .baud_tick(baud_tick), .tx_DATA(tx_DATA),
    .tx_valid(vld[0]), .tx_ready(ready_a[0]), .txd(txd_a[0]), .tx_busy(busy_a[0]),
    .tx_done(done_a[0]), .fifo_count(cnt_a[0])
  );
  uart_transmitter #(.PARITY_EN(1), .PARITY_ODD(0)) u_even (
    .clock(clock), .rst_n(rst_n), .baud_tick(baud_tick), .tx_DATA(tx_DATA),
    .tx_valid(vld[1]), .tx_ready(ready_a[1]), .txd(txd_a[1]), .tx_busy(busy_a[1]),
    .tx_done(done_a[1]), .fifo_count(cnt_a[1])
  );
  uart_transmitter #(.PARITY_EN(1), .PARITY_ODD(1)) u_odd (
    .clock(clock), .rst_n(rst_n), .baud_tick(baud_tick), .tx_DATA(tx_DATA),
    .tx_valid(vld[2]), .tx_ready(ready_a[2]), .txd(txd_a[2]), .tx_busy(busy_a[2]),
    .tx_done(done_a[2]), .fifo_count(cnt_a[2])
  );
  uart_transmitter #(.STOP_BITS(2)) u_stop2 (
    .clock(clock), .rst_n(rst_n), .baud_tick(baud_tick), .tx_DATA(tx_DATA),
    .tx_valid(vld[3]), .tx_ready(ready_a[3]), .txd(txd_a[3]), .tx_busy(busy_a[3]),
    .tx_done(done_a[3]), .fifo_count(cnt_a[3])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One bit period: 15 idle clocks, then a single-cycle tick; returns #1 after the tick edge.
  task automatic tick();
    repeat (15) @(posedge clock);
    @(negedge clock);
    baud_tick = 1'b1;
    @(posedge clock);
    #1 baud_tick = 1'b0;
  endtask

  task automatic push(input int k, input logic [7:0] b);
    @(negedge clock);
    tx_DATA = b;
    vld[k]  = 1'b1;
    @(posedge clock);
    #1 vld[k] = 1'b0;
  endtask

  // Expected line level after tick idx of a frame (tick 0 launches the start bit).
  function automatic logic frame_bit(input logic [7:0] b, input int idx, input bit pen,
                                     input bit par_bit);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (pen && idx == 9) return par_bit;
    return 1'b1;
  endfunction

  task automatic send_and_check(input int k, input logic [7:0] b, input int len, input bit pen,
                                input bit par_bit, input string tag);
    push(k, b);
    for (int t = 0; t <= len; t++) begin
      tick();
      chk($sformatf("%s_txd%0d", tag, t), txd_a[k],
          (t < len) ? frame_bit(b, t, pen, par_bit) : 1'b1);
      chk($sformatf("%s_done%0d", tag, t), done_a[k], (t == len));
      if (t == 0) chk($sformatf("%s_busy", tag), busy_a[k], 1);
    end
    chk($sformatf("%s_idle", tag), busy_a[k], 0);
  endtask

  logic [7:0] lb [16];
  logic [7:0] rx;
  int a5_seq [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

  initial begin
    // Reset state on every instance
    repeat (3) @(posedge clock);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_txd%0d", k), txd_a[k], 1);
      chk($sformatf("rst_busy%0d", k), busy_a[k], 0);
      chk($sformatf("rst_done%0d", k), done_a[k], 0);
      chk($sformatf("rst_ready%0d", k), ready_a[k], 1);
      chk($sformatf("rst_cnt%0d", k), cnt_a[k], 0);
    end
    @(negedge clock);
    rst_n = 1'b1;

    // 1: single 0xA5 frame
    push(0, 8'hA5);
    chk("a5_cnt", cnt_a[0], 1);
    chk("a5_txd_prestart", txd_a[0], 1);
    for (int t = 0; t <= 10; t++) begin
      tick();
      chk($sformatf("a5_txd%0d", t), txd_a[0], (t < 10) ? a5_seq[t] : 1);
      chk($sformatf("a5_done%0d", t), done_a[0], (t == 10));
    end
    chk("a5_idle", busy_a[0], 0);
    tick();
    chk("a5_no_extra_done", done_a[0], 0);

    // 2: fill, overflow attempt, then back-to-back frames 0x01..0x05
    for (int i = 1; i <= 4; i++) push(0, 8'(i));
    chk("full_cnt", cnt_a[0], 4);
    chk("full_ready", ready_a[0], 0);
    @(negedge clock);
    tx_DATA = 8'hEE;
    vld[0]  = 1'b1;
    repeat (3) @(posedge clock);
    #1 vld[0] = 1'b0;
    chk("full_ignored_cnt", cnt_a[0], 4);
    for (int t = 0; t <= 50; t++) begin
      tick();
      if (t == 0) begin
        chk("pop_ready", ready_a[0], 1);
        chk("pop_cnt", cnt_a[0], 3);
        push(0, 8'h05);
        chk("refill_cnt", cnt_a[0], 4);
      end
      chk($sformatf("b2b_txd%0d", t), txd_a[0],
          (t < 50) ? frame_bit(8'((t / 10) + 1), t % 10, 0, 0) : 1'b1);
      chk($sformatf("b2b_done%0d", t), done_a[0], (t > 0) && (t % 10 == 0));
    end
    chk("b2b_idle", busy_a[0], 0);
    chk("b2b_empty", cnt_a[0], 0);

    // 3: parity, 0x07 has three ones
    send_and_check(1, 8'h07, 11, 1, 1'b1, "par_even");
    send_and_check(2, 8'h07, 11, 1, 1'b0, "par_odd");

    // 4: two stop bits
    send_and_check(3, 8'h00, 11, 0, 1'b0, "stop2");

    // 5: reset during data bit 3 of 0xC3 with another byte queued
    push(0, 8'hC3);
    push(0, 8'h77);
    tick();
    chk("mid_cnt", cnt_a[0], 1);
    repeat (4) tick();
    chk("mid_bit3", txd_a[0], 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_txd", txd_a[0], 1);
    chk("mid_rst_cnt", cnt_a[0], 0);
    chk("mid_rst_ready", ready_a[0], 1);
    chk("mid_rst_busy", busy_a[0], 0);
    @(negedge clock);
    rst_n = 1'b1;
    for (int t = 0; t < 12; t++) begin
      tick();
      chk($sformatf("post_rst_done%0d", t), done_a[0], 0);
      chk($sformatf("post_rst_txd%0d", t), txd_a[0], 1);
    end
    send_and_check(0, 8'h96, 10, 0, 1'b0, "clean");

    // 6: loopback of 16 random bytes decoded from the line on the shared tick
    for (int i = 0; i < 16; i++) lb[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) push(0, lb[i]);
    tick();
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("lb_start%0d", i), txd_a[0], 0);
      if (i + 4 < 16) push(0, lb[i+4]);
      for (int b = 0; b < 8; b++) begin
        tick();
        rx[b] = txd_a[0];
      end
      tick();
      chk($sformatf("lb_stop%0d", i), txd_a[0], 1);
      tick();
      chk($sformatf("lb_done%0d", i), done_a[0], 1);
      chk($sformatf("lb_byte%0d", i), rx, lb[i]);
    end
    chk("lb_final_txd", txd_a[0], 1);
    chk("lb_final_busy", busy_a[0], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
